// File: rtl/prga_decrypt_fsm_if.sv
// S-memory, encrypted ROM and decrypted RAM buses plus start/status handshake
// between the RC4 PRGA/decrypt FSM (master) and its memories/controller (slave).
interface prga_decrypt_fsm_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic              valid_message;
    logic [7:0]        s_data_in;
    logic [7:0]        s_address_out;
    logic [7:0]        s_data_out;
    logic              s_write_enable_out;
    logic [7:0]        rom_data_in;
    logic [ADDR_W-1:0] rom_address_out;
    logic [ADDR_W-1:0] dec_address_out;
    logic [7:0]        dec_data_out;
    logic              dec_write_enable_out;

    modport master (
        input  start, s_data_in, rom_data_in,
        output busy, done, valid_message,
               s_address_out, s_data_out, s_write_enable_out,
               rom_address_out,
               dec_address_out, dec_data_out, dec_write_enable_out
    );

    modport slave (
        output start, s_data_in, rom_data_in,
        input  busy, done, valid_message,
               s_address_out, s_data_out, s_write_enable_out,
               rom_address_out,
               dec_address_out, dec_data_out, dec_write_enable_out
    );
endinterface

// File: rtl/prga_decrypt_fsm.sv
// RC4 PRGA over the shuffled S array, XOR with encrypted ROM, plaintext into decrypted RAM.
// Optional ASCII_CHECK_EN: abort the run on the first byte outside 'a'..'z' / space.
//
// state             | meaning
// IDLE              | waiting for start
// INC_I .. CAP_SJ   | i++, read S[i] and ROM[k], j += S[i], read S[j]
// WR_SI / WR_SJ     | swap S[i] and S[j]
// RD_F .. WR_DEC    | read S[si+sj], write plaintext byte k
// NEXT/FINISH/ABORT | advance k or end the run
module prga_decrypt_fsm #(
    parameter int MSG_LENGTH = 32,
    parameter int ADDR_W     = 5
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    prga_decrypt_fsm_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, INC_I, RD_SI, WT_SI, CAP_SI, RD_SJ, WT_SJ, CAP_SJ,
        WR_SI, WR_SJ, RD_F, WT_F, WR_DEC, NEXT, FINISH, ABORT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LENGTH - 1);

    state_t            state;
    logic [7:0]        i;
    logic [7:0]        j;
    logic [ADDR_W-1:0] k;
    logic [7:0]        si;
    logic [7:0]        sj;
    logic [7:0]        enc;

`ifdef ASCII_CHECK_EN
    function automatic logic is_legal(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction
`endif

    // Memory addresses are registered one state early so they are stable
    // for the whole read/wait/capture window of each access.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state                    <= IDLE;
            i                        <= '0;
            j                        <= '0;
            k                        <= '0;
            si                       <= '0;
            sj                       <= '0;
            enc                      <= '0;
            bus.busy                 <= 1'b0;
            bus.done                 <= 1'b0;
            bus.valid_message        <= 1'b0;
            bus.s_address_out        <= '0;
            bus.s_data_out           <= '0;
            bus.s_write_enable_out   <= 1'b0;
            bus.rom_address_out      <= '0;
            bus.dec_address_out      <= '0;
            bus.dec_data_out         <= '0;
            bus.dec_write_enable_out <= 1'b0;
        end else begin
            bus.s_write_enable_out   <= 1'b0;
            bus.dec_write_enable_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        i                 <= '0;
                        j                 <= '0;
                        k                 <= '0;
                        bus.done          <= 1'b0;
                        bus.valid_message <= 1'b0;
                        bus.busy          <= 1'b1;
                        state             <= INC_I;
                    end
                end
                INC_I: begin
                    i                   <= i + 8'd1;
                    bus.s_address_out   <= i + 8'd1;
                    bus.rom_address_out <= k;
                    state               <= RD_SI;
                end
                RD_SI: state <= WT_SI;
                WT_SI: state <= CAP_SI;
                CAP_SI: begin
                    si                <= bus.s_data_in;
                    enc               <= bus.rom_data_in;
                    j                 <= j + bus.s_data_in;
                    bus.s_address_out <= j + bus.s_data_in;
                    state             <= RD_SJ;
                end
                RD_SJ: state <= WT_SJ;
                WT_SJ: state <= CAP_SJ;
                CAP_SJ: begin
                    sj                     <= bus.s_data_in;
                    bus.s_address_out      <= i;
                    bus.s_data_out         <= bus.s_data_in;
                    bus.s_write_enable_out <= 1'b1;
                    state                  <= WR_SI;
                end
                WR_SI: begin
                    bus.s_address_out      <= j;
                    bus.s_data_out         <= si;
                    bus.s_write_enable_out <= 1'b1;
                    state                  <= WR_SJ;
                end
                WR_SJ: begin
                    bus.s_address_out <= si + sj;
                    state             <= RD_F;
                end
                RD_F: state <= WT_F;
                WT_F: begin
                    bus.dec_address_out      <= k;
                    bus.dec_data_out         <= bus.s_data_in ^ enc;
                    bus.dec_write_enable_out <= 1'b1;
                    state                    <= WR_DEC;
                end
                WR_DEC: begin
`ifdef ASCII_CHECK_EN
                    state <= is_legal(bus.dec_data_out) ? NEXT : ABORT;
`else
                    state <= NEXT;
`endif
                end
                NEXT: begin
                    if (k == LAST_K) begin
                        state <= FINISH;
                    end else begin
                        k     <= k + 1'b1;
                        state <= INC_I;
                    end
                end
                FINISH: begin
                    bus.done          <= 1'b1;
                    bus.valid_message <= 1'b1;
                    bus.busy          <= 1'b0;
                    state             <= IDLE;
                end
                ABORT: begin
                    bus.done          <= 1'b1;
                    bus.valid_message <= 1'b0;
                    bus.busy          <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/prga_decrypt_fsm.md
Name: prga_decrypt_fsm

Overview:
- Consumer side of the S-memory interface: starts once the shuffle has finished writing the S array.
- Runs the RC4 pseudo-random generation loop over the shuffled S array, including the swap writes back into S.
- XORs each keystream byte with the matching encrypted ROM byte and writes the plaintext into a decrypted-message RAM.
- Flags whether the decrypted message is valid, for the key-search controller.

Parameters:
MSG_LENGTH, 32, number of bytes decrypted per run (ROM and decrypted RAM depth)
ADDR_W, 5, width of ROM and decrypted RAM address (clog2 of MSG_LENGTH)

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; aborts any run and returns to IDLE
start  input  1  one-cycle pulse, sampled only in IDLE
s_data_in  input  8  S-memory q
s_address_out  output  8  S-memory address
s_data_out  output  8  S-memory write data
s_write_enable_out  output  1  S-memory wren
rom_data_in  input  8  encrypted ROM q
rom_address_out  output  ADDR_W  encrypted ROM address
dec_address_out  output  ADDR_W  decrypted RAM address
dec_data_out  output  8  decrypted RAM write data
dec_write_enable_out  output  1  decrypted RAM wren
busy  output  1  high from the cycle after start is accepted until done
done  output  1  level; high once the run ends, cleared by reset or the next accepted start
valid_message  output  1  qualified by done

Behaviour:
- Reset values: all address, data, and enable outputs 0; busy=0, done=0, valid_message=0.
- Internal state on reset: i=0, j=0, k=0, state=IDLE.
- Memory timing, S and ROM: the address driven in cycle N is registered at edge N+1; q is sampled at edge N+2. Every read therefore goes through one WAIT state.
- Writes take effect at the edge where wren=1. A read issued on the cycle after a write returns the new data.
- All index arithmetic is 8-bit with modulo-256 wrap: i, j, and (si+sj). k counts from 0 to MSG_LENGTH-1.
- State machine:
  - IDLE: on start, clear i, j, k, done, valid_message; go to INC_I.
  - INC_I: i<=i+1.
  - RD_SI: s_address_out=i, rom_address_out=k.
  - WT_SI: wait.
  - CAP_SI: si<=s_data_in, enc<=rom_data_in, j<=j+s_data_in.
  - RD_SJ: s_address_out=j.
  - WT_SJ: wait.
  - CAP_SJ: sj<=s_data_in.
  - WR_SI: address i, data sj, wren=1.
  - WR_SJ: address j, data si, wren=1.
  - RD_F: address si+sj.
  - WT_F: wait.
  - WR_DEC: dec_address_out=k, dec_data_out=s_data_in^enc, dec_write_enable_out=1.
  - NEXT: if k==MSG_LENGTH-1 go to FINISH; else k<=k+1 and go to INC_I.
  - FINISH: done<=1, valid_message<=1, busy<=0; go to IDLE.
- Per-byte cost is 13 cycles. A full run is 1 + 13*MSG_LENGTH + 1 cycles from start to done.
- Boundary: i==j gives two writes of the same value; this is legal and leaves S unchanged.
- Boundary: i wraps 255→0 naturally; this only matters for MSG_LENGTH>255, which is unsupported.
- All wren outputs are low in every state other than the write states above.
- start while busy is ignored.
- reset mid-run returns to IDLE next edge with all outputs at reset values. No further writes occur, and partial RAM/S contents are left as-is.
- The block does not reinitialise S; the upstream fill/shuffle stages own that.

Optional Feature:
Macro ASCII_CHECK_EN.
- Defined: in WR_DEC, the decrypted byte is checked. If it is neither 0x61..0x7A nor 0x20, the byte is still written, then the FSM goes to ABORT.
  - ABORT sets done=1, valid_message=0, busy=0 and returns to IDLE.
  - A full run with all bytes legal ends with valid_message=1.
- Undefined: no check is made; every run processes all MSG_LENGTH bytes and ends with valid_message=1.

Test Plan:
1. S model preloaded identity (S[x]=x), ROM[0..2]=0x63,0x64,0x62, pulse start → dec[0..2]=0x61,0x61,0x65 (keystream 0x02,0x05,0x07); after byte 2, S[2]=3, S[3]=5, S[5]=2.
2. Same setup, MSG_LENGTH=32, ROM all 0x20-compatible → done rises exactly 2+13*32 cycles after start; busy high throughout; exactly 32 dec writes, addresses 0..31 in order.
3. Pulse start again 20 cycles into a run → no restart; dec write sequence and done timing identical to scenario 2.
4. Assert reset for one cycle at cycle 100 of a run → next cycle all wren=0, busy=0, done=0; a fresh start then reproduces scenario 1 results (after reloading identity S).
5. ASCII_CHECK_EN defined, identity S, ROM[0]=0x00 → dec[0]=0x02 written, done=1, valid_message=0, no dec write to address 1.
6. Bench S-memory checker: at every cycle assert that the read data used matches the 2-cycle latency model and that no S write ever occurs outside WR_SI/WR_SJ.
